skeleton_host: RTL and testbench
================================

# skeleton_host

Host-side sequencer for the DUT skeleton register bus. It takes operand words from an upstream command stream (UART/SPI bridge) and writes them into a skeleton's input RAM. It then fires the calculation trigger, waits for the skeleton's ready flag, and reads the result words back into a downstream result stream. One instance sits between the communication bridge and each skeleton (math, filter, etc.); the skeleton's header word tells it how many operands to write and how many results to read.

## Interface
- BITWIDTH_SYS, 16, data bus width on device
- BITWIDTH_ADR, 6, skeleton address width
- BITWIDTH_HEAD, 26, skeleton header width
- TIMEOUT_CYC, 1023, maximum cycles waiting for skeleton ready
- CLK_SYS in 1: system clock; single clock domain
- RST in 1: reset, synchronous, active-high
- CMD_DATA in BITWIDTH_SYS: operand word
- CMD_VALID in 1 / CMD_READY out 1: command handshake
- RES_DATA out BITWIDTH_SYS: result word
- RES_VALID out 1 / RES_READY in 1: result handshake
- SKL_EN out 1: skeleton enable
- SKL_TRGG out 1: trigger pulse, drives TRGG_START_CALC
- SKL_RnW out 1: 1 = read, 0 = write
- SKL_ADR out BITWIDTH_ADR: skeleton address
- SKL_DOUT out BITWIDTH_SYS: write data, drives skeleton DATA_IN
- SKL_DIN in BITWIDTH_SYS: skeleton DATA_OUT
- SKL_HEAD in BITWIDTH_HEAD: skeleton DATA_HEAD
- SKL_RDY in 1: skeleton ready
- BUSY out 1: job in progress
- ERR_TIMEOUT out 1: sticky timeout flag

## Operation
- Header decode:
  - N_IN = SKL_HEAD[21:16]
  - N_OUT = SKL_HEAD[15:10]
  - Both are latched on job start.
- States: IDLE, LOAD, TRIG, WAIT_GUARD, WAIT_RDY, READ_ADR, READ_CAP, SEND.
- IDLE:
  - A job starts when CMD_VALID=1 and SKL_RDY=1. The FSM latches N_IN/N_OUT and clears the word counter k.
  - If N_IN=0, go to TRIG; otherwise go to LOAD.
- LOAD:
  - CMD_READY=1.
  - On each handshake, the next cycle drives SKL_RnW=0, SKL_ADR=k, SKL_DOUT=CMD_DATA for exactly one cycle, then k++.
  - After N_IN writes, go to TRIG.
- TRIG: SKL_TRGG=1 for one cycle, then go to WAIT_GUARD.
- WAIT_GUARD: one cycle in which SKL_RDY is ignored, because the skeleton's run flag is not yet visible.
- WAIT_RDY:
  - Count cycles.
  - On SKL_RDY=1, reset k and go to READ_ADR. If N_OUT=0, go to IDLE instead.
  - If the count reaches TIMEOUT_CYC, set ERR_TIMEOUT, emit no results, and go to IDLE.
- READ_ADR: drive SKL_RnW=1, SKL_ADR=k for one cycle.
- READ_CAP: register SKL_DIN into RES_DATA, then go to SEND.
- SEND:
  - Hold RES_VALID=1 and RES_DATA stable until RES_READY=1.
  - Then k++. If k<N_OUT, go to READ_ADR; otherwise go to IDLE.
- Outside write cycles, SKL_RnW=1, so no spurious skeleton writes occur.
- ERR_TIMEOUT clears only on RST. A new job may start while it is set.
- CMD words arriving outside LOAD are not accepted (CMD_READY=0).

## Timing
- All outputs are registered.
- Reset values:
  - CMD_READY=0, RES_VALID=0, RES_DATA=0
  - SKL_EN=0, SKL_TRGG=0, SKL_RnW=1, SKL_ADR=0, SKL_DOUT=0
  - BUSY=0, ERR_TIMEOUT=0
- SKL_EN rises the first cycle after RST deasserts and stays high.
- BUSY=1 from the cycle after job start until the cycle IDLE is re-entered.
- Each operand costs 2 cycles minimum (handshake cycle, then write cycle). Upstream stalls extend LOAD indefinitely; no timeout applies in LOAD.
- TRIG immediately follows the last write cycle. The skeleton samples its RAM write before the trigger edge.
- Each result costs 3 cycles minimum (READ_ADR, READ_CAP, SEND). Downstream stalls hold SEND indefinitely.
- RST mid-job:
  - Abort the job and return to IDLE next cycle with reset values.
  - Any partially loaded operands and the skeleton state are discarded; SKL_EN=0 resets the skeleton.
- If RES_READY=1 and a new CMD_VALID=1 arrive in the same last-SEND cycle, the new job starts no earlier than the following cycle, from IDLE.

## Structure
- Shared package skeleton_pkg holds:
  - FSM state encoding
  - header field offsets (type [25:22], N_IN [21:16], N_OUT [15:10], BITWIDTH_IN [9:5], BITWIDTH_OUT [4:0])
  - the read/write constants RnW_READ=1, RnW_WRITE=0
- No sub-module. The FSM, word counter, and timeout counter are all local.

## Test plan
- Signed-multiply skeleton (header N_IN=2, N_OUT=1, 8-bit inputs): CMD 0x0300, then 0xFE00 -> exactly one RES word 0xFFFA. Writes land at ADR 0 and 1, and exactly one TRGG pulse occurs.
- Same job with RES_READY held low for 20 cycles -> RES_VALID stays high and RES_DATA stays 0xFFFA for all 20 cycles; a single transfer occurs on release.
- Skeleton model with SKL_RDY stuck low, TIMEOUT_CYC=16 -> ERR_TIMEOUT=1 at cycle 16 of WAIT_RDY, no RES_VALID, FSM back in IDLE. The next good job (3×3) returns 0x0009 with ERR_TIMEOUT still 1.
- Header N_IN=3, N_OUT=2 model, with gaps in CMD_VALID -> writes at ADR 0,1,2 in order, reads at ADR 0,1, and two RES words in address order.
- RST asserted during LOAD after the first operand -> all outputs return to reset values next cycle and CMD_READY=0. A subsequent full job produces correct results.
- Header N_OUT=0 -> the trigger fires, the FSM waits for RDY, and it returns to IDLE with no RES_VALID.

Source files
------------

// File: rtl/skeleton_pkg.sv
// Shared definitions for skeleton register-bus hosts: FSM encoding, header
// field layout and the bus read/write polarity.
package skeleton_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_TRIG,
        ST_WAIT_GUARD,
        ST_WAIT_RDY,
        ST_READ_ADR,
        ST_READ_CAP,
        ST_SEND
    } state_t;

    localparam int HEAD_TYPE_MSB   = 25;
    localparam int HEAD_TYPE_LSB   = 22;
    localparam int HEAD_N_IN_MSB   = 21;
    localparam int HEAD_N_IN_LSB   = 16;
    localparam int HEAD_N_OUT_MSB  = 15;
    localparam int HEAD_N_OUT_LSB  = 10;
    localparam int HEAD_BW_IN_MSB  = 9;
    localparam int HEAD_BW_IN_LSB  = 5;
    localparam int HEAD_BW_OUT_MSB = 4;
    localparam int HEAD_BW_OUT_LSB = 0;

    // Word counts and the word index share the N_IN field width.
    localparam int N_W = HEAD_N_IN_MSB - HEAD_N_IN_LSB + 1;
    typedef logic [N_W-1:0] count_t;

    localparam logic RnW_READ  = 1'b1;
    localparam logic RnW_WRITE = 1'b0;

endpackage

// File: rtl/skeleton_host.sv
// Host-side sequencer: streams operands into a skeleton's input RAM, triggers
// the calculation, waits for ready and streams the result words back out.
module skeleton_host
    import skeleton_pkg::*;
#(
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_ADR  = 6,
    parameter int BITWIDTH_HEAD = 26,
    parameter int TIMEOUT_CYC   = 1023
) (
    input  logic                     CLK_SYS,
    input  logic                     RST,
    input  logic [BITWIDTH_SYS-1:0]  CMD_DATA,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    output logic [BITWIDTH_SYS-1:0]  RES_DATA,
    output logic                     RES_VALID,
    input  logic                     RES_READY,
    output logic                     SKL_EN,
    output logic                     SKL_TRGG,
    output logic                     SKL_RnW,
    output logic [BITWIDTH_ADR-1:0]  SKL_ADR,
    output logic [BITWIDTH_SYS-1:0]  SKL_DOUT,
    input  logic [BITWIDTH_SYS-1:0]  SKL_DIN,
    input  logic [BITWIDTH_HEAD-1:0] SKL_HEAD,
    input  logic                     SKL_RDY,
    output logic                     BUSY,
    output logic                     ERR_TIMEOUT
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    state_t                  state_q, state_d;
    count_t                  n_in_q, n_in_d, n_out_q, n_out_d;
    count_t                  k_q, k_d, k_next, adr_q, adr_d;
    logic [TMO_W-1:0]        tcnt_q, tcnt_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic [BITWIDTH_SYS-1:0] res_data_q, res_data_d;
    logic [BITWIDTH_SYS-1:0] dout_q, dout_d;
    logic                    trgg_q, trgg_d;
    logic                    rnw_q, rnw_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    en_q;
    logic                    head_unused;

    // Type and bit-width fields describe the skeleton but do not steer sequencing.
    assign head_unused = ^{SKL_HEAD[HEAD_TYPE_MSB:HEAD_TYPE_LSB],
                           SKL_HEAD[HEAD_BW_IN_MSB:HEAD_BW_IN_LSB],
                           SKL_HEAD[HEAD_BW_OUT_MSB:HEAD_BW_OUT_LSB]};

    assign k_next = k_q + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        n_in_d      = n_in_q;
        n_out_d     = n_out_q;
        k_d         = k_q;
        adr_d       = adr_q;
        tcnt_d      = tcnt_q;
        cmd_ready_d = 1'b0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        dout_d      = dout_q;
        trgg_d      = 1'b0;
        rnw_d       = RnW_READ;
        busy_d      = busy_q;
        err_d       = err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (en_q && CMD_VALID && SKL_RDY) begin
                    n_in_d  = SKL_HEAD[HEAD_N_IN_MSB:HEAD_N_IN_LSB];
                    n_out_d = SKL_HEAD[HEAD_N_OUT_MSB:HEAD_N_OUT_LSB];
                    k_d     = '0;
                    busy_d  = 1'b1;
                    if (SKL_HEAD[HEAD_N_IN_MSB:HEAD_N_IN_LSB] == '0) begin
                        state_d = ST_TRIG;
                        trgg_d  = 1'b1;
                    end else begin
                        state_d     = ST_LOAD;
                        cmd_ready_d = 1'b1;
                    end
                end
            end

            // Alternates handshake cycle (ready high) and write cycle (RnW low).
            ST_LOAD: begin
                if (cmd_ready_q && CMD_VALID) begin
                    rnw_d  = RnW_WRITE;
                    adr_d  = k_q;
                    dout_d = CMD_DATA;
                end else if (rnw_q == RnW_WRITE) begin
                    k_d = k_next;
                    if (k_next == n_in_q) begin
                        state_d = ST_TRIG;
                        trgg_d  = 1'b1;
                    end else begin
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            ST_TRIG: state_d = ST_WAIT_GUARD;

            ST_WAIT_GUARD: begin
                tcnt_d  = '0;
                state_d = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
                if (SKL_RDY) begin
                    k_d = '0;
                    if (n_out_q == '0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_READ_ADR;
                        adr_d   = '0;
                    end
                end else if (tcnt_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_READ_ADR: state_d = ST_READ_CAP;

            ST_READ_CAP: begin
                res_data_d  = SKL_DIN;
                res_valid_d = 1'b1;
                state_d     = ST_SEND;
            end

            ST_SEND: begin
                if (RES_READY) begin
                    k_d = k_next;
                    if (k_next < n_out_q) begin
                        state_d = ST_READ_ADR;
                        adr_d   = k_next;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    res_valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK_SYS) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            n_in_q      <= '0;
            n_out_q     <= '0;
            k_q         <= '0;
            adr_q       <= '0;
            tcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            dout_q      <= '0;
            trgg_q      <= 1'b0;
            rnw_q       <= RnW_READ;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            n_in_q      <= n_in_d;
            n_out_q     <= n_out_d;
            k_q         <= k_d;
            adr_q       <= adr_d;
            tcnt_q      <= tcnt_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            dout_q      <= dout_d;
            trgg_q      <= trgg_d;
            rnw_q       <= rnw_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            en_q        <= 1'b1;
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RES_VALID   = res_valid_q;
    assign RES_DATA    = res_data_q;
    assign SKL_EN      = en_q;
    assign SKL_TRGG    = trgg_q;
    assign SKL_RnW     = rnw_q;
    assign SKL_ADR     = BITWIDTH_ADR'(adr_q);
    assign SKL_DOUT    = dout_q;
    assign BUSY        = busy_q;
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_skeleton_host.sv
// Bench for skeleton_host: behavioural skeleton model, directed jobs, and a
// result scoreboard drained by an independent monitor.
module tb_skeleton_host;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        skl_en;
    logic        skl_trgg;
    logic        skl_rnw;
    logic [5:0]  skl_adr;
    logic [15:0] skl_dout;
    logic [15:0] skl_din;
    logic [25:0] skl_head;
    logic        skl_rdy;
    logic        busy;
    logic        err_timeout;

    always #5 clk = ~clk;

    skeleton_host #(
        .BITWIDTH_SYS (16),
        .BITWIDTH_ADR (6),
        .BITWIDTH_HEAD(26),
        .TIMEOUT_CYC  (16)
    ) dut (
        .CLK_SYS    (clk),
        .RST        (rst),
        .CMD_DATA   (cmd_data),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .RES_DATA   (res_data),
        .RES_VALID  (res_valid),
        .RES_READY  (res_ready),
        .SKL_EN     (skl_en),
        .SKL_TRGG   (skl_trgg),
        .SKL_RnW    (skl_rnw),
        .SKL_ADR    (skl_adr),
        .SKL_DOUT   (skl_dout),
        .SKL_DIN    (skl_din),
        .SKL_HEAD   (skl_head),
        .SKL_RDY    (skl_rdy),
        .BUSY       (busy),
        .ERR_TIMEOUT(err_timeout)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Skeleton model: mode 0 = signed 8x8 multiply of upper bytes, mode 1 = sum / difference.
    logic [15:0] ram_in  [8];
    logic [15:0] ram_out [8];
    logic        rdy_m;
    int          lat;
    int          mode  = 0;
    bit          stuck = 1'b0;

    assign skl_rdy = rdy_m;

    function automatic logic [15:0] mul8(input logic [15:0] x, input logic [15:0] y);
        logic signed [15:0] a, b;
        a = {{8{x[15]}}, x[15:8]};
        b = {{8{y[15]}}, y[15:8]};
        return 16'(a * b);
    endfunction

    always @(posedge clk) begin
        if (!skl_en) begin
            rdy_m   <= 1'b1;
            lat     <= 0;
            skl_din <= '0;
            for (int i = 0; i < 8; i++) begin
                ram_in[i]  <= '0;
                ram_out[i] <= '0;
            end
        end else begin
            if (!skl_rnw) ram_in[skl_adr[2:0]] <= skl_dout;
            skl_din <= ram_out[skl_adr[2:0]];
            if (skl_trgg) begin
                rdy_m <= 1'b0;
                lat   <= 4;
                if (mode == 0) begin
                    ram_out[0] <= mul8(ram_in[0], ram_in[1]);
                end else begin
                    ram_out[0] <= ram_in[0] + ram_in[1] + ram_in[2];
                    ram_out[1] <= ram_in[0] - ram_in[2];
                end
            end else if (!rdy_m && !stuck) begin
                if (lat == 0) rdy_m <= 1'b1;
                else          lat   <= lat - 1;
            end
        end
    end

    // Monitor / scoreboard
    logic [15:0] exp_q [$];
    logic [5:0]  wr_log [$];
    logic [15:0] exp_word;
    int          trig_cnt     = 0;
    int          xfer_cnt     = 0;
    int          valid_cycles = 0;

    always @(negedge clk) begin
        if (skl_trgg) trig_cnt++;
        if (skl_en && skl_rnw == 1'b0) wr_log.push_back(skl_adr);
        if (res_valid) valid_cycles++;
        if (res_valid && res_ready) begin
            xfer_cnt++;
            check("res_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_word = exp_q.pop_front();
                check("res_data", 64'(res_data), 64'(exp_word));
            end
        end
    end

    function automatic logic [25:0] mk_head(input int n_in, input int n_out);
        return (26'd1 << 22) | (26'(n_in) << 16) | (26'(n_out) << 10) | (26'd8 << 5) | 26'd16;
    endfunction

    localparam logic [44:0] RESET_VEC = {1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 6'h00, 16'h0000, 1'b0, 1'b0};

    function automatic logic [44:0] out_vec();
        return {cmd_ready, res_valid, res_data, skl_en, skl_trgg, skl_rnw, skl_adr, skl_dout, busy, err_timeout};
    endfunction

    int trig_base;

    task automatic send_word(input logic [15:0] d);
        int n = 0;
        cmd_data  = d;
        cmd_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            n++;
            if (n > 200) begin
                check("cmd_accept", 64'(cmd_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic load_job(input logic [25:0] h, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input int n, input int gap);
        logic [15:0] w [3];
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        skl_head = h;
        wr_log.delete();
        trig_base = trig_cnt;
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(posedge clk);
            #1;
            send_word(w[i]);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic post_checks(input string name, input int n);
        check({name, "_trig_pulses"}, 64'(trig_cnt - trig_base), 64'd1);
        check({name, "_write_count"}, 64'(wr_log.size()), 64'(n));
        for (int i = 0; i < n && i < wr_log.size(); i++)
            check({name, "_write_adr"}, 64'(wr_log[i]), 64'(i));
        check({name, "_results_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_job(input string name, input logic [25:0] h, input logic [15:0] w0,
                           input logic [15:0] w1, input logic [15:0] w2, input int n, input int gap);
        load_job(h, w0, w1, w2, n, gap);
        wait_idle(name);
        post_checks(name, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  base_x, base_v, n;
        bit  hold_ok;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        res_ready = 1'b1;
        skl_head  = mk_head(2, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("en_after_reset", 64'(skl_en), 64'd1);

        // Signed multiply: 3 * -2
        mode = 0;
        exp_q.push_back(16'hFFFA);
        base_x = xfer_cnt;
        run_job("mul", mk_head(2, 1), 16'h0300, 16'hFE00, 16'h0000, 2, 0);
        check("mul_xfers", 64'(xfer_cnt - base_x), 64'd1);

        // Same job with downstream stalled for 20 cycles
        exp_q.push_back(16'hFFFA);
        base_x    = xfer_cnt;
        res_ready = 1'b0;
        load_job(mk_head(2, 1), 16'h0300, 16'hFE00, 16'h0000, 2, 0);
        n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", 64'(res_valid), 64'd1);
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 16'hFFFA) hold_ok = 1'b0;
        end
        check("stall_hold", 64'(hold_ok), 64'd1);
        check("stall_no_early_xfer", 64'(xfer_cnt - base_x), 64'd0);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle("stall");
        post_checks("stall", 2);
        check("stall_xfers", 64'(xfer_cnt - base_x), 64'd1);

        // Skeleton never reports ready: timeout after 16 WAIT_RDY cycles
        stuck  = 1'b1;
        base_v = valid_cycles;
        load_job(mk_head(2, 1), 16'h0300, 16'h0300, 16'h0000, 2, 0);
        n = 0;
        while (!skl_trgg && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tmo_trigger_seen", 64'(skl_trgg), 64'd1);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 10) check("tmo_err_not_yet", 64'(err_timeout), 64'd0);
        end
        check("tmo_err_set", 64'(err_timeout), 64'd1);
        check("tmo_back_idle", 64'(busy), 64'd0);
        check("tmo_no_results", 64'(valid_cycles - base_v), 64'd0);
        stuck = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Next good job: 3 * 3, error stays sticky
        exp_q.push_back(16'h0009);
        run_job("after_tmo", mk_head(2, 1), 16'h0300, 16'h0300, 16'h0000, 2, 0);
        check("err_sticky", 64'(err_timeout), 64'd1);

        // Three operands, two results, gaps on the command stream
        mode = 1;
        exp_q.push_back(16'h0033);
        exp_q.push_back(16'h000D);
        base_x = xfer_cnt;
        run_job("n3_n2", mk_head(3, 2), 16'h0010, 16'h0020, 16'h0003, 3, 3);
        check("n3_n2_xfers", 64'(xfer_cnt - base_x), 64'd2);

        // Reset in the middle of LOAD
        mode     = 0;
        skl_head = mk_head(2, 1);
        send_word(16'h0300);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", 64'(out_vec()), 64'(RESET_VEC));
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(16'hFFFA);
        run_job("post_rst", mk_head(2, 1), 16'h0300, 16'hFE00, 16'h0000, 2, 0);

        // No result words requested
        base_v = valid_cycles;
        run_job("nout0", mk_head(1, 0), 16'h0500, 16'h0000, 16'h0000, 1, 0);
        check("nout0_no_results", 64'(valid_cycles - base_v), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
